mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 83 ++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: byte-wide RAM responder with an optional memory-mapped TX byte FIFO.
// Define MEM_RESPONDER_IO_EN to enable the IO region (0x30000 push, 0x30004 count).
module mem_responder #(
    parameter int RAM_AW = 17,
    parameter int TXQ_AW = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        rdy_out,
    output logic [7:0]  io_tx_data,
    output logic        io_tx_valid,
    input  logic        io_tx_ready
);
    logic [7:0] ram [2**RAM_AW];
    logic [7:0] mem_din_q, rd_data;
    logic       is_ram, ram_we;
    logic       unused_bits;

    assign is_ram  = !mem_a[17];
    assign ram_we  = is_ram && mem_wr && rdy_out;
    assign mem_din = mem_din_q;

`ifdef MEM_RESPONDER_IO_EN
    localparam int DEPTH = 2**TXQ_AW;
    logic [7:0]        fifo [DEPTH];
    logic [TXQ_AW:0]   count_q, count_d;
    logic [TXQ_AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic              is_tx, is_stat, push, pop;

    assign is_tx       = mem_a[17:0] == 18'h30000;
    assign is_stat     = mem_a[17:0] == 18'h30004;
    assign rdy_out     = count_q != (TXQ_AW+1)'(DEPTH);
    assign io_tx_valid = count_q != '0;
    assign io_tx_data  = fifo[rd_ptr_q];
    // A push blocked by a full FIFO stays blocked even if a pop frees space this edge
    assign push        = is_tx && mem_wr && rdy_out;
    assign pop         = io_tx_valid && io_tx_ready;
    assign rd_data     = is_ram ? ram[mem_a[RAM_AW-1:0]] : is_stat ? 8'(count_q) : 8'h00;
    assign unused_bits = ^mem_a[31:18];

    always_comb begin
        count_d  = count_q + (TXQ_AW+1)'(push) - (TXQ_AW+1)'(pop);
        rd_ptr_d = rd_ptr_q + TXQ_AW'(pop);
        wr_ptr_d = wr_ptr_q + TXQ_AW'(push);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) fifo[wr_ptr_q] <= mem_dout;
    end
`else
    assign rdy_out     = 1'b1;
    assign io_tx_valid = 1'b0;
    assign io_tx_data  = 8'h00;
    assign rd_data     = is_ram ? ram[mem_a[RAM_AW-1:0]] : 8'h00;
    assign unused_bits = ^{mem_a[31:18], io_tx_ready, TXQ_AW[0]};
`endif

    // Read data is captured every cycle, so a write edge returns the pre-write byte
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) mem_din_q <= 8'h00;
        else mem_din_q <= rd_data;
    end

    always_ff @(posedge clk_in) begin
        if (ram_we) ram[mem_a[RAM_AW-1:0]] <= mem_dout;
    end
endmodule
